// File: rtl/tp_pkg.sv
// Shared link definitions for the serial memory loader.
// Holds the link mode encoding and the frame field widths. The upstream
// loader imports the same package, so both ends agree on the frame layout.
package tp_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'b00,
        MODE_IMEM = 2'b01,
        MODE_DMEM = 2'b10,
        MODE_RUN  = 2'b11
    } mode_t;

    // Frame payload: address LSBs first, then the data byte.
    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = ADDR_W + DATA_W;

endpackage

// File: rtl/sipo_shift.sv
// Serial-in/parallel-out frame register with a bit counter.
// Bits enter at the MSB end and shift right, so after WIDTH shifts the
// first bit received sits in bit 0.
//   clk, rst_n : clock and active-low async reset
//   i_clr      : clear register and counter (start of a frame)
//   i_en       : take i_din and advance the counter
//   i_din      : serial data
//   o_data     : parallel register contents
//   o_cnt      : number of bits taken since the last clear
module sipo_shift #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_din,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_cnt
);

    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_en) begin
            r_sr  <= {i_din, r_sr[WIDTH-1:1]};
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_data = r_sr;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/load_rx.sv
// Serial memory loader receiver.
// Receives address/data frames on mosi_in (LSB first) and issues one
// registered write strobe per good frame to the imem or dmem bank; also
// gates the core execute enable in run mode.
//   clk, rst_n : clock, async active-low reset (release synchronised)
//   mosi_in    : serial frame data
//   mode_in    : 00 idle, 01 imem load, 10 dmem load, 11 run
//   wr_en      : one-cycle write strobe
//   wr_sel     : 0 imem, 1 dmem
//   wr_addr    : write address (held between strobes)
//   wr_data    : write data (held between strobes)
//   run_out    : core execute enable
//   bank_full  : pulses with the write to the last bank address
//   frame_err  : sticky framing/sequence error, cleared only by reset
//
// state  | meaning
// IDLE   | waiting for a load or run mode
// PRE    | preamble cycle of the link, no bit taken
// SHIFT  | collecting frame bits while mode matches the latched mode
// COMMIT | write strobe cycle
// RUN    | core enabled while mode stays 11
module load_rx
    import tp_pkg::*;
#(
    parameter int FRAME_BITS = tp_pkg::FRAME_BITS,
    parameter int NWORDS     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mosi_in,
    input  logic [1:0]        mode_in,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              run_out,
    output logic              bank_full,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FRAME_BITS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NWORDS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRE    = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_COMMIT = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    logic [2:0]            r_state;
    logic [2:0]            w_next;
    mode_t                 r_cur_mode;
    logic                  r_ovr;
    logic [ADDR_W-1:0]     r_exp_imem;
    logic [ADDR_W-1:0]     r_exp_dmem;
    logic [1:0]            r_seq_vld;
    logic                  r_wr_en;
    logic                  r_wr_sel;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [DATA_W-1:0]     r_wr_data;
    logic                  r_run;
    logic                  r_bank_full;
    logic                  r_frame_err;

    logic                  w_clr;
    logic                  w_shift;
    logic                  w_commit;
    logic                  w_err;
    logic                  w_ovr_set;
    logic [FRAME_BITS-1:0] w_sr;
    logic [CNT_W-1:0]      w_cnt;
    logic [ADDR_W-1:0]     w_addr;
    logic [DATA_W-1:0]     w_data;
    logic                  w_sel;
    logic [ADDR_W-1:0]     w_exp;
    logic                  w_seq_err;
    logic [ADDR_W-1:0]     w_exp_next;

    // Assertion reaches every flop at once; release is seen two edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    sipo_shift #(.WIDTH(FRAME_BITS), .CNT_W(CNT_W)) u_sipo (
        .clk    (clk),
        .rst_n  (w_rst_n),
        .i_clr  (w_clr),
        .i_en   (w_shift),
        .i_din  (mosi_in),
        .o_data (w_sr),
        .o_cnt  (w_cnt)
    );

    always_comb begin
        w_next    = r_state;
        w_clr     = 1'b0;
        w_shift   = 1'b0;
        w_commit  = 1'b0;
        w_err     = 1'b0;
        w_ovr_set = 1'b0;
        case (r_state)
            ST_IDLE, ST_RUN: begin
                if (mode_in == MODE_IMEM || mode_in == MODE_DMEM) begin
                    w_next = ST_PRE;
                    w_clr  = 1'b1;
                end else if (mode_in == MODE_RUN) begin
                    w_next = ST_RUN;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_PRE: w_next = ST_SHIFT;
            ST_SHIFT: begin
                if (mode_in == MODE_IDLE) begin
                    if (!r_ovr && w_cnt == FULL_CNT) begin
                        w_next   = ST_COMMIT;
                        w_commit = 1'b1;
                    end else begin
                        // An overrun frame was already flagged when it overran.
                        w_next = ST_IDLE;
                        w_err  = !r_ovr;
                    end
                end else if (mode_in != r_cur_mode) begin
                    w_next = ST_IDLE;
                    w_err  = 1'b1;
                end else if (!r_ovr) begin
                    if (w_cnt == FULL_CNT) begin
                        w_err     = 1'b1;
                        w_ovr_set = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                    end
                end
            end
            ST_COMMIT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign w_addr = w_sr[ADDR_W-1:0];
    assign w_data = w_sr[ADDR_W +: DATA_W];
    assign w_sel  = (r_cur_mode == MODE_DMEM);
    assign w_exp  = w_sel ? r_exp_dmem : r_exp_imem;
    // The sequence check arms after the first commit to a bank, so a load
    // may begin at any address after reset.
    assign w_seq_err  = r_seq_vld[w_sel] && (w_addr != w_exp);
    assign w_exp_next = (w_addr == LAST_ADDR) ? '0 : w_addr + 1'b1;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_cur_mode  <= MODE_IDLE;
            r_ovr       <= 1'b0;
            r_exp_imem  <= '0;
            r_exp_dmem  <= '0;
            r_seq_vld   <= 2'b00;
            r_wr_en     <= 1'b0;
            r_wr_sel    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_run       <= 1'b0;
            r_bank_full <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= (w_next == ST_RUN);
            if (w_clr) begin
                r_cur_mode <= mode_t'(mode_in);
                r_ovr      <= 1'b0;
            end else if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end
            r_wr_en     <= w_commit;
            r_bank_full <= w_commit && (w_addr == LAST_ADDR);
            if (w_commit) begin
                r_wr_sel  <= w_sel;
                r_wr_addr <= w_addr;
                r_wr_data <= w_data;
                r_seq_vld[w_sel] <= 1'b1;
                if (w_sel) r_exp_dmem <= w_exp_next;
                else       r_exp_imem <= w_exp_next;
            end
            if (w_err || (w_commit && w_seq_err)) r_frame_err <= 1'b1;
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_sel    = r_wr_sel;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign run_out   = r_run;
    assign bank_full = r_bank_full;
    assign frame_err = r_frame_err;

endmodule
